// File: rtl/deck_pkg.sv
// rtl/deck_pkg.sv - shared FSM encodings, widths and card value helpers for deck_shuffler
package deck_pkg;

  typedef logic [2:0] deck_state_t;

  localparam deck_state_t ST_IDLE    = 3'd0;
  localparam deck_state_t ST_INIT    = 3'd1;
  localparam deck_state_t ST_SHUFFLE = 3'd2;
  localparam deck_state_t ST_READY   = 3'd3;
  localparam deck_state_t ST_EMPTY   = 3'd4;

  localparam int RANKS_PER_SUIT = 13;

  // Bits needed to encode values 0..n-1, never less than one.
  function automatic int width_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Ace counts as 1 here; the controller decides when it becomes 11.
  function automatic logic [3:0] rank_value(input int unsigned card_idx);
    int unsigned rank;
    rank = card_idx % RANKS_PER_SUIT;
    if (rank < 9) return 4'(rank + 1);
    else return 4'd10;
  endfunction

endpackage

// File: rtl/deck_shuffler_lfsr_gen.sv
// rtl/deck_shuffler_lfsr_gen.sv - Galois LFSR with seed load, zero-seed fallback and enable
module lfsr_gen
  import deck_pkg::*;
#(
  parameter int           W    = 16,
  parameter logic [W-1:0] TAPS = 16'hB400,
  parameter logic [W-1:0] SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] seed_in,
  output logic [W-1:0] value
);

  logic [W-1:0] next_value;

  always_comb begin
    next_value = value >> 1;
    if (value[0]) next_value = (value >> 1) ^ TAPS;
  end

  // A zero seed would lock the register, so it falls back to SEED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       value <= SEED;
    else if (load) value <= (seed_in == '0) ? SEED : seed_in;
    else if (en)   value <= next_value;
  end

endmodule

// File: rtl/deck_shuffler.sv
// rtl/deck_shuffler.sv - multi-deck Fisher-Yates shoe shuffler and dealer; CARD_VALUE_EN adds card_value
module deck_shuffler
  import deck_pkg::*;
#(
  parameter int                NUM_DECKS      = 1,
  parameter int                CARDS_PER_DECK = 52,
  parameter int                LFSR_W         = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS      = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED           = 16'hACE1,
  localparam int               TOTAL          = NUM_DECKS * CARDS_PER_DECK,
  localparam int               CARD_W         = width_of(CARDS_PER_DECK),
  localparam int               CNT_W          = width_of(TOTAL + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shuffle_req,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              deal_req,
  output logic              busy,
  output logic              deck_ready,
  output logic              deal_valid,
  output logic [CARD_W-1:0] card,
  output logic [CNT_W-1:0]  cards_left,
  output logic              empty,
`ifdef CARD_VALUE_EN
  output logic [3:0]        card_value,
`endif
  output logic              deal_err
);

  localparam int IDX_W = width_of(TOTAL);

  deck_state_t         state;
  logic [LFSR_W-1:0]   lfsr;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    j;
  logic [CARD_W-1:0]   init_val;
  logic [IDX_W:0]      span;
  logic [LFSR_W+IDX_W-1:0] prod;
  logic [CARD_W-1:0]   deck [TOTAL];

  lfsr_gen #(.W(LFSR_W), .TAPS(LFSR_TAPS), .SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .en      (1'b1),
    .load    (seed_load),
    .seed_in (seed_in),
    .value   (lfsr)
  );

  // Multiply-high maps the LFSR onto 0..idx without a divider.
  assign span = {1'b0, idx} + {{IDX_W{1'b0}}, 1'b1};
  assign prod = {{IDX_W{1'b0}}, lfsr} * {{(LFSR_W-1){1'b0}}, span};
  assign j    = IDX_W'(prod >> LFSR_W);

  assign busy       = (state == ST_INIT) || (state == ST_SHUFFLE);
  assign deck_ready = (state == ST_READY);
  assign empty      = (state == ST_EMPTY);

  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      deck[idx] <= init_val;
    end else if (state == ST_SHUFFLE) begin
      deck[idx] <= deck[j];
      deck[j]   <= deck[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      ptr        <= '0;
      init_val   <= '0;
      card       <= '0;
      cards_left <= '0;
      deal_valid <= 1'b0;
      deal_err   <= 1'b0;
`ifdef CARD_VALUE_EN
      card_value <= 4'd0;
`endif
    end else begin
      deal_valid <= 1'b0;
      deal_err   <= 1'b0;
      case (state)
        ST_IDLE, ST_EMPTY: begin
          deal_err <= deal_req;
          if (shuffle_req) begin
            state    <= ST_INIT;
            idx      <= '0;
            init_val <= '0;
          end
        end
        ST_INIT: begin
          deal_err <= deal_req;
          init_val <= (init_val == CARD_W'(CARDS_PER_DECK - 1)) ? '0 : init_val + CARD_W'(1);
          if (idx == IDX_W'(TOTAL - 1)) state <= ST_SHUFFLE;
          else idx <= idx + IDX_W'(1);
        end
        ST_SHUFFLE: begin
          deal_err <= deal_req;
          if (idx == IDX_W'(1)) begin
            state      <= ST_READY;
            ptr        <= '0;
            cards_left <= CNT_W'(TOTAL);
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        ST_READY: begin
          // A reshuffle request beats a same-cycle deal, which is then rejected.
          if (shuffle_req) begin
            state      <= ST_INIT;
            idx        <= '0;
            init_val   <= '0;
            cards_left <= '0;
            deal_err   <= deal_req;
          end else if (deal_req) begin
            card       <= deck[ptr];
            deal_valid <= 1'b1;
            ptr        <= ptr + IDX_W'(1);
            cards_left <= cards_left - CNT_W'(1);
`ifdef CARD_VALUE_EN
            card_value <= rank_value(32'(deck[ptr]));
`endif
            if (cards_left == CNT_W'(1)) state <= ST_EMPTY;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_deck_shuffler.sv
// tb/tb_deck_shuffler.sv - self-checking bench for deck_shuffler against a Fisher-Yates reference model
module tb_deck_shuffler;

  logic        clk = 1'b0;
  logic        rst;
  logic        shuffle_req, seed_load, deal_req;
  logic [15:0] seed_in;
  logic        busy, deck_ready, deal_valid, empty, deal_err;
  logic [5:0]  card, cards_left;
  logic        shuffle_req2, seed_load2, deal_req2;
  logic [15:0] seed_in2;
  logic        busy2, deck_ready2, deal_valid2, empty2, deal_err2;
  logic [5:0]  card2;
  logic [6:0]  cards_left2;
`ifdef CARD_VALUE_EN
  logic [3:0]  card_value, card_value2;
`endif

  int checks = 0;
  int errors = 0;
  int exp_deck [0:415];
  int m_ptr;
  int dealt[$];
  int seq_a[$];
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  deck_shuffler dut (
    .clk(clk), .rst(rst), .shuffle_req(shuffle_req), .seed_load(seed_load), .seed_in(seed_in),
    .deal_req(deal_req), .busy(busy), .deck_ready(deck_ready), .deal_valid(deal_valid),
    .card(card), .cards_left(cards_left), .empty(empty),
`ifdef CARD_VALUE_EN
    .card_value(card_value),
`endif
    .deal_err(deal_err)
  );

  deck_shuffler #(.NUM_DECKS(2)) dut2 (
    .clk(clk), .rst(rst), .shuffle_req(shuffle_req2), .seed_load(seed_load2), .seed_in(seed_in2),
    .deal_req(deal_req2), .busy(busy2), .deck_ready(deck_ready2), .deal_valid(deal_valid2),
    .card(card2), .cards_left(cards_left2), .empty(empty2),
`ifdef CARD_VALUE_EN
    .card_value(card_value2),
`endif
    .deal_err(deal_err2)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Reference LFSR: reset to the default seed, reload on seed_load, otherwise step every cycle.
  always @(posedge clk or posedge rst) begin
    if (rst)            m_lfsr <= 16'hACE1;
    else if (seed_load) m_lfsr <= (seed_in == 16'd0) ? 16'hACE1 : seed_in;
    else                m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // l0 is the LFSR value in the first INIT cycle; swaps start total cycles later.
  task automatic build_expected(input logic [15:0] l0, input int total);
    logic [15:0] lf;
    int jj, tmp;
    for (int k = 0; k < total; k++) exp_deck[k] = k % 52;
    lf = l0;
    repeat (total) lf = lfsr_step(lf);
    for (int i = total - 1; i >= 1; i--) begin
      jj = int'((longint'(lf) * longint'(i + 1)) >>> 16);
      tmp = exp_deck[i];
      exp_deck[i] = exp_deck[jj];
      exp_deck[jj] = tmp;
      lf = lfsr_step(lf);
    end
    m_ptr = 0;
  endtask

  task automatic start_shuffle;
    shuffle_req = 1'b1;
    tick;
    shuffle_req = 1'b0;
    build_expected(m_lfsr, 52);
  endtask

  task automatic wait_ready(input int total, input int sh_at, input int dl_at);
    int n;
    n = 0;
    while (deck_ready !== 1'b1 && n < 4 * total) begin
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_during_shuffle cycle %0d got %b want 1", n + 1, busy); end
      if (n == sh_at) shuffle_req = 1'b1;
      if (n == dl_at) deal_req = 1'b1;
      tick;
      n++;
      shuffle_req = 1'b0;
      if (deal_req) begin
        deal_req = 1'b0;
        checks++;
        if (deal_err !== 1'b1 || deal_valid !== 1'b0) begin
          errors++; $display("FAIL deal_while_busy got err=%b valid=%b want err=1 valid=0", deal_err, deal_valid);
        end
      end
    end
    checks++;
    if (n + 1 != 2 * total) begin errors++; $display("FAIL ready_latency got %0d want %0d", n + 1, 2 * total); end
    checks++;
    if (busy !== 1'b0 || cards_left !== 6'(total)) begin
      errors++; $display("FAIL ready_state got busy=%b left=%0d want busy=0 left=%0d", busy, cards_left, total);
    end
  endtask

  task automatic deal_n(input int n, input int total);
    int got, guard, rank;
    bit dr;
    got = 0;
    guard = 0;
    dealt.delete();
    while (got < n && guard < 2000) begin
      dr = ($urandom_range(0, 3) != 0);
      deal_req = dr;
      tick;
      guard++;
      checks++;
      if (deal_valid !== dr) begin errors++; $display("FAIL deal_valid got %b want %b", deal_valid, dr); end
      checks++;
      if (deal_err !== 1'b0) begin errors++; $display("FAIL deal_err_in_ready got %b want 0", deal_err); end
      if (dr) begin
        checks++;
        if (card !== 6'(exp_deck[m_ptr])) begin
          errors++; $display("FAIL card[%0d] got %0d want %0d", m_ptr, card, exp_deck[m_ptr]);
        end
`ifdef CARD_VALUE_EN
        rank = exp_deck[m_ptr] % 13;
        checks++;
        if (card_value !== 4'((rank < 9) ? rank + 1 : 10)) begin
          errors++; $display("FAIL card_value card %0d got %0d want %0d", exp_deck[m_ptr], card_value, (rank < 9) ? rank + 1 : 10);
        end
`else
        rank = 0;
`endif
        m_ptr++;
        got++;
        checks++;
        if (cards_left !== 6'(total - m_ptr)) begin
          errors++; $display("FAIL cards_left got %0d want %0d", cards_left, total - m_ptr);
        end
        dealt.push_back(int'(card));
      end
    end
    deal_req = 1'b0;
    checks++;
    if (got != n) begin errors++; $display("FAIL deal_timeout got %0d want %0d", got, n); end
    if (m_ptr == total) begin
      checks++;
      if (empty !== 1'b1 || deck_ready !== 1'b0 || cards_left !== 6'd0) begin
        errors++; $display("FAIL empty_state got empty=%b ready=%b left=%0d want 1 0 0", empty, deck_ready, cards_left);
      end
    end
  endtask

  task automatic load_seed(input logic [15:0] s);
    seed_in = s;
    seed_load = 1'b1;
    tick;
    seed_load = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({busy, deck_ready, deal_valid, deal_err, empty, card, cards_left} !== 17'd0) begin
      errors++; $display("FAIL reset_outputs got %b want 0", {busy, deck_ready, deal_valid, deal_err, empty, card, cards_left});
    end
    rst = 1'b0;
    tick;
    checks++;
    if ({busy, deck_ready, empty, busy2, deck_ready2} !== 5'd0) begin
      errors++; $display("FAIL idle_after_reset got %b want 0", {busy, deck_ready, empty, busy2, deck_ready2});
    end
  endtask

  task automatic test_idle_deal;
    deal_req = 1'b1;
    tick;
    deal_req = 1'b0;
    checks++;
    if (deal_err !== 1'b1 || deal_valid !== 1'b0) begin
      errors++; $display("FAIL idle_deal got err=%b valid=%b want 1 0", deal_err, deal_valid);
    end
    tick;
    checks++;
    if (deal_err !== 1'b0) begin errors++; $display("FAIL deal_err_pulse got %b want 0", deal_err); end
  endtask

  task automatic test_full_deal;
    int cnt [52];
    int bad;
    start_shuffle;
    wait_ready(52, -1, -1);
    deal_n(52, 52);
    foreach (cnt[i]) cnt[i] = 0;
    foreach (dealt[i]) if (dealt[i] < 52) cnt[dealt[i]]++;
    bad = 0;
    foreach (cnt[i]) if (cnt[i] != 1) bad++;
    checks++;
    if (bad != 0 || dealt.size() != 52) begin
      errors++; $display("FAIL permutation got %0d bad values (%0d dealt) want 0 (52)", bad, dealt.size());
    end
    seq_a = dealt;
  endtask

  task automatic test_empty_err;
    deal_req = 1'b1;
    tick;
    deal_req = 1'b0;
    checks++;
    if (deal_err !== 1'b1 || deal_valid !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL empty_deal got err=%b valid=%b empty=%b want 1 0 1", deal_err, deal_valid, empty);
    end
  endtask

  task automatic test_reshuffle_differs;
    int same;
    start_shuffle;
    wait_ready(52, -1, -1);
    deal_n(52, 52);
    same = 0;
    foreach (dealt[i]) if (dealt[i] == seq_a[i]) same++;
    checks++;
    if (same == 52) begin errors++; $display("FAIL reshuffle_order got %0d equal positions want fewer than 52", same); end
  endtask

  task automatic test_ready_shuffle_priority;
    start_shuffle;
    wait_ready(52, -1, -1);
    deal_n(int'($urandom_range(1, 20)), 52);
    shuffle_req = 1'b1;
    deal_req = 1'b1;
    tick;
    shuffle_req = 1'b0;
    deal_req = 1'b0;
    checks++;
    if (deal_err !== 1'b1 || deal_valid !== 1'b0 || busy !== 1'b1 || cards_left !== 6'd0 || empty !== 1'b0) begin
      errors++; $display("FAIL shuffle_beats_deal got err=%b valid=%b busy=%b left=%0d empty=%b want 1 0 1 0 0",
                         deal_err, deal_valid, busy, cards_left, empty);
    end
    build_expected(m_lfsr, 52);
    wait_ready(52, -1, -1);
    deal_n(52, 52);
  endtask

  task automatic test_busy_injections;
    start_shuffle;
    wait_ready(52, 70, 10);
    deal_n(52, 52);
  endtask

  task automatic test_seed_reload;
    int diff;
    logic [15:0] s;
    load_seed(16'h1234);
    start_shuffle;
    wait_ready(52, -1, -1);
    deal_n(52, 52);
    seq_a = dealt;
    repeat ($urandom_range(1, 9)) tick;
    load_seed(16'h1234);
    start_shuffle;
    wait_ready(52, -1, -1);
    deal_n(52, 52);
    diff = 0;
    foreach (dealt[i]) if (dealt[i] != seq_a[i]) diff++;
    checks++;
    if (diff != 0) begin errors++; $display("FAIL seed_repeat got %0d differing positions want 0", diff); end
    s = 16'($urandom_range(1, 65535));
    load_seed(s);
    start_shuffle;
    wait_ready(52, -1, -1);
    deal_n(52, 52);
  endtask

  task automatic test_seed_zero;
    int diff;
    load_seed(16'h0000);
    start_shuffle;
    wait_ready(52, -1, -1);
    deal_n(52, 52);
    seq_a = dealt;
    load_seed(16'hACE1);
    start_shuffle;
    wait_ready(52, -1, -1);
    deal_n(52, 52);
    diff = 0;
    foreach (dealt[i]) if (dealt[i] != seq_a[i]) diff++;
    checks++;
    if (diff != 0) begin errors++; $display("FAIL zero_seed_fallback got %0d differing positions want 0", diff); end
  endtask

  task automatic test_reset_mid_shuffle;
    start_shuffle;
    repeat (59) tick;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, deck_ready, deal_valid, deal_err, empty, card, cards_left} !== 17'd0) begin
      errors++; $display("FAIL mid_shuffle_reset got %b want 0", {busy, deck_ready, deal_valid, deal_err, empty, card, cards_left});
    end
    tick;
    rst = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0 || deck_ready !== 1'b0) begin
      errors++; $display("FAIL idle_after_mid_reset got busy=%b ready=%b want 0 0", busy, deck_ready);
    end
    start_shuffle;
    wait_ready(52, -1, -1);
    deal_n(52, 52);
  endtask

  task automatic test_two_decks;
    int n, bad;
    int cnt [52];
    shuffle_req2 = 1'b1;
    tick;
    shuffle_req2 = 1'b0;
    n = 0;
    while (deck_ready2 !== 1'b1 && n < 1000) begin tick; n++; end
    checks++;
    if (n + 1 != 208) begin errors++; $display("FAIL two_deck_latency got %0d want 208", n + 1); end
    checks++;
    if (cards_left2 !== 7'd104) begin errors++; $display("FAIL two_deck_left got %0d want 104", cards_left2); end
    foreach (cnt[i]) cnt[i] = 0;
    deal_req2 = 1'b1;
    bad = 0;
    for (int k = 0; k < 104; k++) begin
      tick;
      if (deal_valid2 !== 1'b1) bad++;
      else if (card2 < 6'd52) cnt[card2]++;
    end
    deal_req2 = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL two_deck_held_deal got %0d missing valids want 0", bad); end
    bad = 0;
    foreach (cnt[i]) if (cnt[i] != 2) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL two_deck_counts got %0d values not seen twice want 0", bad); end
    checks++;
    if (empty2 !== 1'b1 || cards_left2 !== 7'd0) begin
      errors++; $display("FAIL two_deck_empty got empty=%b left=%0d want 1 0", empty2, cards_left2);
    end
  endtask

  initial begin
    rst = 1'b1;
    shuffle_req = 1'b0; seed_load = 1'b0; seed_in = 16'd0; deal_req = 1'b0;
    shuffle_req2 = 1'b0; seed_load2 = 1'b0; seed_in2 = 16'd0; deal_req2 = 1'b0;
    tick;
    tick;
    test_reset;
    test_idle_deal;
    test_full_deal;
    test_empty_err;
    test_reshuffle_differs;
    test_ready_shuffle_priority;
    test_busy_injections;
    test_seed_reload;
    test_seed_zero;
    test_reset_mid_shuffle;
    test_two_decks;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/deck_shuffler.md
Name: deck_shuffler

Overview:
Parametrised successor to the single-deck shuffle block. Builds a shoe of NUM_DECKS x CARDS_PER_DECK card indices and shuffles it in hardware with Fisher-Yates (one swap per cycle) driven by an LFSR. Deals cards one at a time over a request/valid handshake to the blackjack controller. Supports reshuffle on demand and a runtime seed.

Parameters:
NUM_DECKS, 1, decks in the shoe (1..8)
CARDS_PER_DECK, 52, cards per deck; card index range 0..CARDS_PER_DECK-1, suits contiguous in groups of 13
LFSR_W, 16, LFSR width
LFSR_TAPS, 16'hB400, Galois tap mask (x^16+x^14+x^13+x^11+1)
SEED, 16'hACE1, reset/fallback seed; must be nonzero

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
shuffle_req  in  1  start init+shuffle (single-cycle pulse)
seed_load  in  1  load seed_in into LFSR (takes priority over LFSR advance)
seed_in  in  LFSR_W  seed value; zero is replaced by SEED
deal_req  in  1  request the next card
busy  out  1  high during INIT/SHUFFLE
deck_ready  out  1  high in READY (cards remain)
deal_valid  out  1  one-cycle pulse: card is valid
card  out  clog2(CARDS_PER_DECK)  dealt card index, held until the next deal
cards_left  out  clog2(TOTAL+1)  undealt cards; TOTAL = NUM_DECKS*CARDS_PER_DECK
empty  out  1  all cards dealt
deal_err  out  1  one-cycle pulse: deal_req rejected

Behaviour:
- Reset: state IDLE; busy=0, deck_ready=0, deal_valid=0, deal_err=0, card=0, cards_left=0, empty=0; LFSR=SEED. Deck contents undefined.
- The LFSR advances every cycle in every state except reset. seed_load overrides the advance in that cycle.
- States:
  - IDLE: shuffle_req -> INIT.
  - INIT: on consecutive cycles, write deck[k] = k mod CARDS_PER_DECK for k = 0..TOTAL-1 (TOTAL cycles), then -> SHUFFLE with i = TOTAL-1.
  - SHUFFLE: each cycle, j = (lfsr * (i+1)) >> LFSR_W (multiply-high, no modulo), then swap deck[i] and deck[j] in the same cycle. Decrement i. After the cycle with i = 1 -> READY, with ptr = 0 and cards_left = TOTAL. Takes TOTAL-1 cycles.
  - READY: deal_req at edge N -> at N+1: card = deck[ptr], deal_valid = 1, ptr++, cards_left--. When cards_left reaches 0 -> EMPTY: empty = 1, deck_ready = 0.
  - EMPTY: deal_req -> deal_err pulse at N+1. shuffle_req -> INIT.
- busy=1 exactly in INIT/SHUFFLE. From shuffle_req to deck_ready: 2*TOTAL cycles (104 for a single 52-card deck).
- shuffle_req in READY abandons the remaining cards: -> INIT, cards_left=0, empty=0.
- shuffle_req in INIT/SHUFFLE: ignored.
- deal_req in IDLE, INIT or SHUFFLE: deal_err pulse, no deal_valid.
- deal_req and shuffle_req in the same cycle in READY: the shuffle wins; deal_err is pulsed.
- deal_req is level-sampled: holding it high in READY deals one card per cycle.
- Reset mid-operation returns to IDLE immediately; a partial shuffle is discarded.

Optional Feature:
Macro CARD_VALUE_EN.
- Defined: adds output card_value [3:0], registered alongside card. rank = card mod 13; value = rank+1 for rank 0..8, 10 for rank 9..12 (ace = 1; the controller promotes to 11). Reset value 0.
- Undefined: port and logic absent. All other behaviour is identical.

Decomposition:
- Package deck_pkg: state enum (IDLE, INIT, SHUFFLE, READY, EMPTY), RANKS_PER_SUIT = 13, rank-to-value function, width helper for card/count widths.
- Sub-module lfsr_gen: parametrised Galois LFSR with load, seed fallback, and an enable input.
- Deck storage stays inline as a register array.

Test Plan:
- Reset, shuffle_req, default seed -> busy for 104 cycles, then deck_ready=1 and cards_left=52. 52 deals return every value 0..51 exactly once. Then empty=1 and cards_left=0.
- In EMPTY, deal_req -> deal_err pulse, no deal_valid. shuffle_req -> busy; the new order differs from the first shuffle.
- NUM_DECKS=2 -> busy for 208 cycles; 104 deals, each value 0..51 seen exactly twice.
- seed_load with 16'h1234, two full shuffles each preceded by the same reload -> identical 52-card sequences. seed_in=0 -> behaves as SEED.
- rst pulsed at shuffle cycle 60 -> all outputs reset next sample. shuffle_req during SHUFFLE -> no restart (ready still at cycle 104).
- CARD_VALUE_EN: dealt card 12 -> card_value 10; card 13 -> 1; card 21 -> 9; card 48 -> 10.
